argmax_classifier: RTL
======================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter VAL_SIZE, default 26, width of dot-product result.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of weight sets (classes) evaluated per image; legal range 2..2^CLASS_W.
REQ-003 SHALL have parameter CLASS_W, default 4, width of class index.
REQ-004 SHALL have parameter DP_LATENCY, default 16, cycles from dp_clear deassertion until the dot-product value is final.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port GlobalReset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request to classify the current image; sampled only in IDLE.
REQ-008 SHALL have port value_in  input  VAL_SIZE  dot-product result from upstream dot-product unit, two's-complement signed.
REQ-009 SHALL have port dp_clear  output  1  restart strobe to the dot-product unit (drives its reset).
REQ-010 SHALL have port class_sel  output  CLASS_W  index of weight set currently presented to the dot-product unit.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-013 SHALL have port class_idx  output  CLASS_W  index of winning class.
REQ-014 SHALL have port max_val  output  VAL_SIZE  value_in of winning class.

Function
REQ-015 SHALL implement states IDLE, CLEAR, WAIT, SAMPLE, DONE.
REQ-016 IDLE: start=1 -> CLEAR with class counter k=0; start=0 -> stay.
REQ-017 CLEAR: one cycle; dp_clear=1, class_sel=k; -> WAIT with wait counter 0.
REQ-018 WAIT: dp_clear=0, class_sel=k; counter increments each cycle; exactly DP_LATENCY cycles in WAIT, then -> SAMPLE.
REQ-019 SAMPLE: one cycle; value_in captured at the closing edge; if k=NUM_CLASSES-1 -> DONE, else k=k+1 and -> CLEAR.
REQ-020 Per class SHALL take exactly DP_LATENCY+2 cycles; done SHALL be high in the cycle after the NUM_CLASSES*(DP_LATENCY+2)-th rising edge following the edge that accepted start (180 with defaults).
REQ-021 DONE: one cycle, done=1, class_idx/max_val updated from running registers on the edge entering DONE; -> IDLE.
REQ-022 Class 0 sample SHALL load running max unconditionally; later samples replace it only if value_in > running max (signed compare).
REQ-023 Ties SHALL keep the lower class index.
REQ-024 class_idx and max_val SHALL hold their last DONE values from DONE until the next DONE; unchanged during a new run.
REQ-025 start SHALL be ignored in CLEAR, WAIT, SAMPLE and DONE; no queuing.
REQ-026 class_sel SHALL be 0 in IDLE and DONE; dp_clear SHALL be 0 outside CLEAR.
REQ-027 value_in SHALL be ignored outside SAMPLE.

Reset
REQ-028 GlobalReset=1 at a rising edge SHALL force IDLE, k=0, wait counter=0, running max=0, dp_clear=0, class_sel=0, busy=0, done=0, class_idx=0, max_val=0.
REQ-029 Reset SHALL take priority over start and over any in-progress run; aborted run SHALL produce no done pulse.
REQ-030 First start after reset release SHALL be accepted on the first edge with GlobalReset=0 and start=1.

Verification (NUM_CLASSES=4, DP_LATENCY=3, VAL_SIZE=26)
REQ-031 Basic: start one cycle, value_in per SAMPLE = 5, 40, -3, 12 -> dp_clear pulses 4 times 5 cycles apart, done at 20th edge after start, class_idx=1, max_val=40.
REQ-032 All negative/tie: values -10, -2, -2, -7 -> class_idx=1, max_val=-2 (tie keeps lower index, signed compare).
REQ-033 Busy start: start held high for entire run and after -> second run begins the cycle after DONE (IDLE reached), no earlier; busy low for exactly one IDLE cycle.
REQ-034 Reset mid-run: GlobalReset during WAIT of class 2 -> next cycle all outputs 0, no done; new start runs full 20-cycle sequence.
REQ-035 Hold: after run 1 (class_idx=1, max_val=40), run 2 with values 1, 2, 99, 3 -> outputs stay 1/40 until run 2 DONE, then 2/99.
REQ-036 Outside-SAMPLE noise: value_in=max positive except in SAMPLE cycles -> results depend only on SAMPLE-cycle values.

Source files
------------

// File: rtl/argmax_classifier.sv
// Argmax sequencer: steps a dot-product unit through every class weight set and
// reports the index and value of the largest signed result.
module argmax_classifier #(
  parameter int VAL_SIZE    = 26,
  parameter int NUM_CLASSES = 10,
  parameter int CLASS_W     = 4,
  parameter int DP_LATENCY  = 16
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                start,
  input  logic [VAL_SIZE-1:0] value_in,
  output logic                dp_clear,
  output logic [CLASS_W-1:0]  class_sel,
  output logic                busy,
  output logic                done,
  output logic [CLASS_W-1:0]  class_idx,
  output logic [VAL_SIZE-1:0] max_val
);

  localparam int WAIT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [CLASS_W-1:0] LAST_K    = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(DP_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, SAMPLE, DONE} state_e;

  state_e              state_q, state_d;
  logic [CLASS_W-1:0]  k_q, k_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [VAL_SIZE-1:0] run_max_q, run_max_d;
  logic [CLASS_W-1:0]  run_idx_q, run_idx_d;
  logic [CLASS_W-1:0]  class_idx_q, class_idx_d;
  logic [VAL_SIZE-1:0] max_val_q, max_val_d;

  logic                take_new;
  logic [VAL_SIZE-1:0] win_val;
  logic [CLASS_W-1:0]  win_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wait_q      <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
    end
  end

  // Class 0 always seeds the running max; strict '>' keeps the lower index on ties.
  assign take_new = (k_q == '0) || ($signed(value_in) > $signed(run_max_q));
  assign win_val  = take_new ? value_in : run_max_q;
  assign win_idx  = take_new ? k_q : run_idx_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wait_d      = wait_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    dp_clear    = 1'b0;
    class_sel   = '0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          k_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        dp_clear  = 1'b1;
        class_sel = k_q;
        wait_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        class_sel = k_q;
        if (wait_q == LAST_WAIT) state_d = SAMPLE;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      SAMPLE: begin
        class_sel = k_q;
        run_max_d = win_val;
        run_idx_d = win_idx;
        if (k_q == LAST_K) begin
          class_idx_d = win_idx;
          max_val_d   = win_val;
          state_d     = DONE;
        end else begin
          k_d     = k_q + CLASS_W'(1);
          state_d = CLEAR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;

endmodule
